dir_input_queue: RTL

//  Clocked successor to the combinational direction decoder. Per-button debounce, press-edge detection
//  and reverse-turn rejection feed a parametrised FIFO of pending turns. The FIFO is drained one entry
//  per game tick, so fast double-taps (e.g. UP then LEFT inside one tick) are not lost. Sits between

---
 rtl/dir_input_queue_pkg.sv | 33 +++
 rtl/dir_input_queue_debouncer.sv | 46 ++++
 rtl/dir_input_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dir_input_queue_pkg.sv
// Shared direction encodings, button indices and helpers for the direction input queue.
package dir_input_queue_pkg;

   localparam int unsigned NUM_BTN = 4;

   localparam int unsigned BTN_LEFT  = 0;
   localparam int unsigned BTN_RIGHT = 1;
   localparam int unsigned BTN_UP    = 2;
   localparam int unsigned BTN_DOWN  = 3;

   // Encoding matches the button index so a press maps straight onto a direction.
   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_TOP   = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_e;

   // Opposite pairs differ only in bit 0.
   function automatic dir_e opposite_dir(input dir_e d);
      return dir_e'({d[1], ~d[0]});
   endfunction

   function automatic dir_e btn_to_dir(input logic [NUM_BTN-1:0] onehot);
      dir_e d;
      d = DIR_LEFT;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
         if (onehot[i]) d = dir_e'(2'(i));
      end
      return d;
   endfunction

endpackage

// File: rtl/dir_input_queue_debouncer.sv
// Single-button debouncer: stable level follows raw after DEBOUNCE_CYCLES consecutive differing cycles.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int unsigned DC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [DC_W-1:0] cnt_q, cnt_d;
   logic            stable_q, stable_d;
   logic            rise_q, rise_d;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (raw != stable_q) begin
         if (cnt_q == DC_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = raw;
         end else begin
            cnt_d = cnt_q + DC_W'(1);
         end
      end
      rise_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
      end
   end

   assign stable = stable_q;
   assign rise   = rise_q;

endmodule

// File: rtl/dir_input_queue.sv
// Debounced button presses qualified into a FIFO of pending turns, popped one per game tick.
// Optional INPUT_SYNC_EN adds a 2-flop synchronizer on btn_n.
module dir_input_queue
   import dir_input_queue_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned QUEUE_DEPTH     = 4,
   parameter int unsigned CNT_W           = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       btn_n,
   input  logic             step,
   output logic [1:0]       cur_dir,
   output logic [CNT_W-1:0] queue_count,
   output logic             dir_accept,
   output logic             dir_reject,
   output logic             overflow
);

   localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_stable;
   logic [NUM_BTN-1:0] btn_rise;

`ifdef INPUT_SYNC_EN
   logic [NUM_BTN-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
      end
   end

   assign btn_raw = ~sync2_q;
`else
   assign btn_raw = ~btn_n;
`endif

   for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_deb
      button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk    (clk),
         .reset  (reset),
         .raw    (btn_raw[g]),
         .stable (btn_stable[g]),
         .rise   (btn_rise[g])
      );
   end

   dir_e             mem_q [QUEUE_DEPTH];
   dir_e             mem_d [QUEUE_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_idx;
   logic [CNT_W-1:0] count_q, count_d;
   dir_e             cur_dir_q, cur_dir_d, ref_dir, cand;
   logic             accept_q, accept_d, reject_q, reject_d, ovf_q, ovf_d;
   logic             press_evt, reverse, full, empty, do_push, do_pop;

   // Qualify the press, judge it against the reference direction, update the FIFO.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      cur_dir_d = cur_dir_q;

      press_evt = $onehot(btn_rise) && ((btn_stable & ~btn_rise) == '0);
      cand      = btn_to_dir(btn_rise);
      full      = (count_q == CNT_W'(QUEUE_DEPTH));
      empty     = (count_q == '0);
      tail_idx  = (wr_ptr_q == '0) ? PTR_W'(QUEUE_DEPTH - 1) : wr_ptr_q - PTR_W'(1);
      ref_dir   = empty ? cur_dir_q : mem_q[tail_idx];
      reverse   = (cand == ref_dir) || (cand == opposite_dir(ref_dir));
      do_push   = press_evt && !reverse && !full;
      do_pop    = step && !empty;

      accept_d  = do_push;
      reject_d  = press_evt && reverse;
      ovf_d     = press_evt && !reverse && full;

      if (do_push) begin
         mem_d[wr_ptr_q] = cand;
         wr_ptr_d = (wr_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         cur_dir_d = mem_q[rd_ptr_q];
         rd_ptr_d  = (rd_ptr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(QUEUE_DEPTH); i++) mem_q[i] <= DIR_TOP;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         cur_dir_q <= DIR_TOP;
         accept_q  <= 1'b0;
         reject_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         cur_dir_q <= cur_dir_d;
         accept_q  <= accept_d;
         reject_q  <= reject_d;
         ovf_q     <= ovf_d;
      end
   end

   assign cur_dir     = cur_dir_q;
   assign queue_count = count_q;
   assign dir_accept  = accept_q;
   assign dir_reject  = reject_q;
   assign overflow    = ovf_q;

endmodule
